// File: rtl/hazard_pkg.sv
// Shared types and constants for the hazard scoreboard: the tracked-entry layout,
// the register-file forwarding code and the parameter legality check.
package hazard_pkg;

    // Entry rd field is sized for the widest register file supported (MIPS: 32 regs).
    localparam int RD_W   = 5;
    localparam int FWD_RF = 0;

    typedef struct packed {
        logic            valid;
        logic            wr;
        logic            load;
        logic [RD_W-1:0] rd;
    } entry_t;

    function automatic bit params_legal(int reg_aw, int track, int load_ready);
        return (load_ready >= 1) && (load_ready < track) && (reg_aw >= 1) && (reg_aw <= RD_W);
    endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// ID-stage to hazard scoreboard bundle: operand/destination info in, stall,
// bubble and forwarding selects back out.
interface hazard_scoreboard_if #(
    parameter int REG_AW = 5,
    parameter int TRACK  = 3
);
    localparam int FW = $clog2(TRACK + 1);

    // No valid/ready pair here: id_valid_i qualifies the ID instruction every cycle,
    // and stall_o is the back-pressure (the ID instruction is only consumed when
    // id_valid_i & !stall_o & !flush_i); the answer is combinational in the same cycle.
    logic              id_valid_i;
    logic [REG_AW-1:0] id_rs_i;
    logic [REG_AW-1:0] id_rt_i;
    logic              id_use_rs_i;
    logic              id_use_rt_i;
    logic              id_wr_i;
    logic [REG_AW-1:0] id_rd_i;
    logic              id_load_i;
    logic              flush_i;
    logic              stall_o;
    logic              bubble_o;
    logic [FW-1:0]     fwd_rs_o;
    logic [FW-1:0]     fwd_rt_o;
    logic [FW-1:0]     inflight_o;

    modport master (
        output id_valid_i, id_rs_i, id_rt_i, id_use_rs_i, id_use_rt_i,
               id_wr_i, id_rd_i, id_load_i, flush_i,
        input  stall_o, bubble_o, fwd_rs_o, fwd_rt_o, inflight_o
    );

    modport slave (
        input  id_valid_i, id_rs_i, id_rt_i, id_use_rs_i, id_use_rt_i,
               id_wr_i, id_rd_i, id_load_i, flush_i,
        output stall_o, bubble_o, fwd_rs_o, fwd_rt_o, inflight_o
    );

endinterface

// File: rtl/hazard_match.sv
// Priority search of the in-flight array for one source register: youngest
// matching writer decides between forwarding from stage k and a load-use hazard.
module hazard_match
    import hazard_pkg::*;
#(
    parameter int TRACK      = 3,
    parameter int LOAD_READY = 1,
    parameter int FW         = $clog2(TRACK + 1)
) (
    input  entry_t [TRACK-1:0] entries,
    input  logic [RD_W-1:0]    src,
    input  logic               use_src,
    output logic               hit,
    output logic               hazard,
    output logic [FW-1:0]      fwd
);

    // Scan oldest to youngest so the youngest match overwrites older ones.
    always_comb begin
        hit    = 1'b0;
        hazard = 1'b0;
        fwd    = FW'(FWD_RF);
        for (int k = TRACK - 1; k >= 0; k--) begin
            if (use_src && entries[k].valid && entries[k].wr &&
                entries[k].rd == src && entries[k].rd != '0) begin
                hit = 1'b1;
                if (entries[k].load && k < LOAD_READY) begin
                    hazard = 1'b1;
                    fwd    = FW'(FWD_RF);
                end else begin
                    hazard = 1'b0;
                    fwd    = FW'(k + 1);
                end
            end
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard/forwarding controller: shift array of in-flight destinations, stall and
// bubble generation, inflight count. HAZARD_PERF_EN adds a saturating stall counter.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int REG_AW     = 5,
    parameter int TRACK      = 3,
    parameter int LOAD_READY = 1,
    parameter int FW         = $clog2(TRACK + 1)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    hazard_scoreboard_if.slave  sb
`ifdef HAZARD_PERF_EN
    ,
    output logic [15:0]         perf_stall_cnt_o
`endif
);

    if (!params_legal(REG_AW, TRACK, LOAD_READY)) begin : g_bad_params
        $error("hazard_scoreboard: need 1 <= LOAD_READY < TRACK and REG_AW <= %0d", RD_W);
    end

    entry_t [TRACK-1:0] entries;
    entry_t             new_entry;
    logic               haz_rs;
    logic               haz_rt;
    logic               hit_rs;
    logic               hit_rt;
    logic [FW-1:0]      fwd_rs;
    logic [FW-1:0]      fwd_rt;
    logic [FW-1:0]      inflight;
    logic               stall;
    logic               unused_hits;

    hazard_match #(.TRACK(TRACK), .LOAD_READY(LOAD_READY), .FW(FW)) u_match_rs (
        .entries (entries),
        .src     (RD_W'(sb.id_rs_i)),
        .use_src (sb.id_use_rs_i),
        .hit     (hit_rs),
        .hazard  (haz_rs),
        .fwd     (fwd_rs)
    );

    hazard_match #(.TRACK(TRACK), .LOAD_READY(LOAD_READY), .FW(FW)) u_match_rt (
        .entries (entries),
        .src     (RD_W'(sb.id_rt_i)),
        .use_src (sb.id_use_rt_i),
        .hit     (hit_rt),
        .hazard  (haz_rt),
        .fwd     (fwd_rt)
    );

    assign unused_hits = hit_rs ^ hit_rt;

    // A flush squashes the ID instruction, so it overrides any hazard it might have.
    assign stall       = sb.id_valid_i & (haz_rs | haz_rt) & ~sb.flush_i;
    assign sb.stall_o  = stall;
    assign sb.bubble_o = stall | sb.flush_i;
    assign sb.fwd_rs_o = fwd_rs;
    assign sb.fwd_rt_o = fwd_rt;

    always_comb begin
        new_entry       = '0;
        new_entry.valid = sb.id_valid_i & ~stall & ~sb.flush_i;
        new_entry.wr    = sb.id_wr_i;
        new_entry.load  = sb.id_load_i;
        new_entry.rd    = RD_W'(sb.id_rd_i);
    end

    // Downstream never freezes: bubbles shift through exactly like instructions.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            entries <= '0;
        end else begin
            entries <= {entries[TRACK-2:0], new_entry};
        end
    end

    always_comb begin
        inflight = '0;
        for (int k = 0; k < TRACK; k++) begin
            inflight = inflight + FW'(entries[k].valid);
        end
    end

    assign sb.inflight_o = inflight;

`ifdef HAZARD_PERF_EN
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            perf_stall_cnt_o <= '0;
        end else if (stall && perf_stall_cnt_o != 16'hFFFF) begin
            perf_stall_cnt_o <= perf_stall_cnt_o + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: default DUT (LOAD_READY=1) plus a
// LOAD_READY=2 DUT on identical stimulus; HAZARD_PERF_EN enables counter checks.
module tb_hazard_scoreboard;

    logic clk_i = 1'b0;
    logic rst_i;
    int   checks = 0;
    int   errors = 0;

    always #5 clk_i = ~clk_i;

    hazard_scoreboard_if #(.REG_AW(5), .TRACK(3)) bus ();
    hazard_scoreboard_if #(.REG_AW(5), .TRACK(3)) bus2 ();

`ifdef HAZARD_PERF_EN
    logic [15:0] perf1;
    logic [15:0] perf2;
`endif

    hazard_scoreboard #(.REG_AW(5), .TRACK(3), .LOAD_READY(1)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .sb    (bus.slave)
`ifdef HAZARD_PERF_EN
        ,
        .perf_stall_cnt_o (perf1)
`endif
    );

    hazard_scoreboard #(.REG_AW(5), .TRACK(3), .LOAD_READY(2)) dut2 (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .sb    (bus2.slave)
`ifdef HAZARD_PERF_EN
        ,
        .perf_stall_cnt_o (perf2)
`endif
    );

    task automatic drive(input logic v, input logic wr, input logic ld, input logic [4:0] rd,
                         input logic [4:0] rs, input logic [4:0] rt,
                         input logic urs, input logic urt, input logic fl);
        bus.id_valid_i  = v;   bus2.id_valid_i  = v;
        bus.id_wr_i     = wr;  bus2.id_wr_i     = wr;
        bus.id_load_i   = ld;  bus2.id_load_i   = ld;
        bus.id_rd_i     = rd;  bus2.id_rd_i     = rd;
        bus.id_rs_i     = rs;  bus2.id_rs_i     = rs;
        bus.id_rt_i     = rt;  bus2.id_rt_i     = rt;
        bus.id_use_rs_i = urs; bus2.id_use_rs_i = urs;
        bus.id_use_rt_i = urt; bus2.id_use_rt_i = urt;
        bus.flush_i     = fl;  bus2.flush_i     = fl;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drain();
        idle();
        repeat (3) step();
    endtask

    task automatic test_reset();
        rst_i = 1'b0;
        idle();
        #3;
        checks++; if (bus.stall_o !== 1'b0) begin errors++; $display("FAIL reset_stall: got %0b want 0", bus.stall_o); end
        checks++; if (bus.bubble_o !== 1'b0) begin errors++; $display("FAIL reset_bubble: got %0b want 0", bus.bubble_o); end
        checks++; if (bus.fwd_rs_o !== 2'd0) begin errors++; $display("FAIL reset_fwd_rs: got %0d want 0", bus.fwd_rs_o); end
        checks++; if (bus.fwd_rt_o !== 2'd0) begin errors++; $display("FAIL reset_fwd_rt: got %0d want 0", bus.fwd_rt_o); end
        checks++; if (bus.inflight_o !== 2'd0) begin errors++; $display("FAIL reset_inflight: got %0d want 0", bus.inflight_o); end
        #9 rst_i = 1'b1;
        step();
        // lw r4 enters entry 0, then a reader of r4 hazards and reset hits mid-stall
        drive(1'b1, 1'b1, 1'b1, 5'd4, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b1, 1'b0, 1'b0, 5'd0, 5'd4, 5'd4, 1'b1, 1'b1, 1'b0);
        #2;
        checks++; if (bus.stall_o !== 1'b1) begin errors++; $display("FAIL pre_reset_stall: got %0b want 1", bus.stall_o); end
        rst_i = 1'b0;
        #1;
        checks++; if (bus.stall_o !== 1'b0) begin errors++; $display("FAIL midstall_reset_stall: got %0b want 0", bus.stall_o); end
        checks++; if (bus.bubble_o !== 1'b0) begin errors++; $display("FAIL midstall_reset_bubble: got %0b want 0", bus.bubble_o); end
        checks++; if (bus.fwd_rs_o !== 2'd0) begin errors++; $display("FAIL midstall_reset_fwd_rs: got %0d want 0", bus.fwd_rs_o); end
        checks++; if (bus.inflight_o !== 2'd0) begin errors++; $display("FAIL midstall_reset_inflight: got %0d want 0", bus.inflight_o); end
        #1 rst_i = 1'b1;
        #1;
        checks++; if (bus.stall_o !== 1'b0) begin errors++; $display("FAIL post_reset_stall: got %0b want 0", bus.stall_o); end
        drain();
    endtask

    task automatic test_alu_fwd();
        drive(1'b1, 1'b1, 1'b0, 5'd3, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b1, 1'b0, 1'b0, 5'd0, 5'd3, 5'd0, 1'b1, 1'b0, 1'b0);
        #2;
        checks++; if (bus.fwd_rs_o !== 2'd1) begin errors++; $display("FAIL alu_fwd_idx0: got %0d want 1", bus.fwd_rs_o); end
        checks++; if (bus.stall_o !== 1'b0) begin errors++; $display("FAIL alu_no_stall: got %0b want 0", bus.stall_o); end
        step();
        #2;
        checks++; if (bus.fwd_rs_o !== 2'd2) begin errors++; $display("FAIL alu_fwd_idx1: got %0d want 2", bus.fwd_rs_o); end
        checks++; if (bus.inflight_o !== 2'd2) begin errors++; $display("FAIL alu_inflight: got %0d want 2", bus.inflight_o); end
        drain();
    endtask

    task automatic test_load_use();
        drive(1'b1, 1'b1, 1'b1, 5'd4, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd4, 1'b0, 1'b1, 1'b0);
        #2;
        checks++; if (bus.stall_o !== 1'b1) begin errors++; $display("FAIL lu_stall: got %0b want 1", bus.stall_o); end
        checks++; if (bus.bubble_o !== 1'b1) begin errors++; $display("FAIL lu_bubble: got %0b want 1", bus.bubble_o); end
        checks++; if (bus.fwd_rt_o !== 2'd0) begin errors++; $display("FAIL lu_fwd_hazard: got %0d want 0", bus.fwd_rt_o); end
        step();
        #2;
        checks++; if (bus.stall_o !== 1'b0) begin errors++; $display("FAIL lu_stall_released: got %0b want 0", bus.stall_o); end
        checks++; if (bus.bubble_o !== 1'b0) begin errors++; $display("FAIL lu_bubble_released: got %0b want 0", bus.bubble_o); end
        checks++; if (bus.fwd_rt_o !== 2'd2) begin errors++; $display("FAIL lu_fwd_mem: got %0d want 2", bus.fwd_rt_o); end
        checks++; if (bus.inflight_o !== 2'd1) begin errors++; $display("FAIL lu_inflight: got %0d want 1", bus.inflight_o); end
        drain();
    endtask

    task automatic test_youngest();
        drive(1'b1, 1'b1, 1'b0, 5'd5, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        step();
        step();
        drive(1'b1, 1'b0, 1'b0, 5'd0, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0);
        #2;
        checks++; if (bus.fwd_rs_o !== 2'd1) begin errors++; $display("FAIL youngest_fwd: got %0d want 1", bus.fwd_rs_o); end
        checks++; if (bus.inflight_o !== 2'd2) begin errors++; $display("FAIL youngest_inflight: got %0d want 2", bus.inflight_o); end
        drain();
        // LOAD_READY=2 instance: two stall cycles then forward from WB
        drive(1'b1, 1'b1, 1'b1, 5'd6, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b1, 1'b0, 1'b0, 5'd0, 5'd6, 5'd0, 1'b1, 1'b0, 1'b0);
        #2;
        checks++; if (bus2.stall_o !== 1'b1) begin errors++; $display("FAIL lr2_stall_c1: got %0b want 1", bus2.stall_o); end
        step();
        #2;
        checks++; if (bus2.stall_o !== 1'b1) begin errors++; $display("FAIL lr2_stall_c2: got %0b want 1", bus2.stall_o); end
        checks++; if (bus2.bubble_o !== 1'b1) begin errors++; $display("FAIL lr2_bubble_c2: got %0b want 1", bus2.bubble_o); end
        step();
        #2;
        checks++; if (bus2.stall_o !== 1'b0) begin errors++; $display("FAIL lr2_stall_c3: got %0b want 0", bus2.stall_o); end
        checks++; if (bus2.fwd_rs_o !== 2'd3) begin errors++; $display("FAIL lr2_fwd: got %0d want 3", bus2.fwd_rs_o); end
        checks++; if (bus2.inflight_o !== 2'd1) begin errors++; $display("FAIL lr2_inflight: got %0d want 1", bus2.inflight_o); end
        drain();
    endtask

    task automatic test_r0_unused();
        drive(1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0);
        #2;
        checks++; if (bus.fwd_rs_o !== 2'd0) begin errors++; $display("FAIL r0_fwd_rs: got %0d want 0", bus.fwd_rs_o); end
        checks++; if (bus.fwd_rt_o !== 2'd0) begin errors++; $display("FAIL r0_fwd_rt: got %0d want 0", bus.fwd_rt_o); end
        checks++; if (bus.inflight_o !== 2'd1) begin errors++; $display("FAIL r0_inflight: got %0d want 1", bus.inflight_o); end
        drain();
        drive(1'b1, 1'b1, 1'b1, 5'd7, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b1, 1'b0, 1'b0, 5'd0, 5'd8, 5'd7, 1'b1, 1'b0, 1'b0);
        #2;
        checks++; if (bus.stall_o !== 1'b0) begin errors++; $display("FAIL unused_rt_stall: got %0b want 0", bus.stall_o); end
        checks++; if (bus.fwd_rt_o !== 2'd0) begin errors++; $display("FAIL unused_rt_fwd: got %0d want 0", bus.fwd_rt_o); end
        drain();
    endtask

    task automatic test_flush();
        drive(1'b1, 1'b1, 1'b1, 5'd9, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b1, 1'b1, 1'b0, 5'd10, 5'd0, 5'd9, 1'b0, 1'b1, 1'b1);
        #2;
        checks++; if (bus.stall_o !== 1'b0) begin errors++; $display("FAIL flush_stall: got %0b want 0", bus.stall_o); end
        checks++; if (bus.bubble_o !== 1'b1) begin errors++; $display("FAIL flush_bubble: got %0b want 1", bus.bubble_o); end
        checks++; if (bus.inflight_o !== 2'd1) begin errors++; $display("FAIL flush_inflight_before: got %0d want 1", bus.inflight_o); end
`ifdef HAZARD_PERF_EN
        // stalled edges so far: one load-use cycle, one LOAD_READY=1 stall in the r6 sequence
        checks++; if (perf1 !== 16'd2) begin errors++; $display("FAIL perf_before_flush: got %0d want 2", perf1); end
`endif
        step();
        idle();
        #2;
        checks++; if (bus.inflight_o !== 2'd1) begin errors++; $display("FAIL flush_inflight_after: got %0d want 1", bus.inflight_o); end
`ifdef HAZARD_PERF_EN
        checks++; if (perf1 !== 16'd2) begin errors++; $display("FAIL perf_after_flush: got %0d want 2", perf1); end
`endif
        drain();
    endtask

    initial begin
        test_reset();
        test_alu_fwd();
        test_load_use();
        test_youngest();
        test_r0_unused();
        test_flush();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
